video_sync_gen_p: RTL

Parametrised video timing generator with a streaming pixel input. It is the successor to the fixed 8-bit LCD sync generator in the SOPC video path. It produces HD/VD/DEN and pixel data for any panel timing, pixel width and sync polarity. It pulls pixels from the frame-buffer reader over a valid/ready/sop stream, aligns each frame to start-of-packet, and recovers from underflow and misalignment on its own.

---
 rtl/video_timing_pkg.sv | 33 +++
 rtl/video_timing_cnt.sv | 77 +++++++
 rtl/video_sync_gen_p.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// ----------------------------------------------------------------------------
// video_timing_pkg
// Shared definitions for the video timing path (sync generator and the
// frame-buffer reader): the frame-lock state type plus helpers that derive
// line/frame totals and counter widths from the porch/sync/active sizes.
// No ports (package).
// ----------------------------------------------------------------------------
package video_timing_pkg;

    // Frame-lock state of the sync generator's stream interface.
    typedef enum logic [0:0] {
        SEEK   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    // Total clocks per line (or lines per frame) from its four segments.
    function automatic int unsigned timing_total(input int unsigned sync_w,
                                                 input int unsigned bp_w,
                                                 input int unsigned act_w,
                                                 input int unsigned fp_w);
        return sync_w + bp_w + act_w + fp_w;
    endfunction

    // Bits needed to count 0..total-1; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned total);
        if (total <= 32'd1) begin
            return 32'd1;
        end else begin
            return $clog2(total);
        end
    endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// ----------------------------------------------------------------------------
// video_timing_cnt
// Free-running horizontal/vertical position counters and the region decode
// derived from them. Line and frame order: sync, back porch, active, front
// porch. All outputs are combinational from the current counter values.
// Ports:
//   clk, rst_n  : pixel clock, asynchronous active-low reset
//   sync_h      : h_cnt inside the HD pulse
//   sync_v      : v_cnt inside the VD pulse
//   act         : current position is a visible pixel
//   first       : current position is pixel (0,0) of the visible area
// ----------------------------------------------------------------------------
module video_timing_cnt
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 480,
    parameter int unsigned H_FP     = 2,
    parameter int unsigned H_SYNC   = 41,
    parameter int unsigned H_BP     = 2,
    parameter int unsigned V_ACTIVE = 272,
    parameter int unsigned V_FP     = 2,
    parameter int unsigned V_SYNC   = 10,
    parameter int unsigned V_BP     = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic sync_h,
    output logic sync_v,
    output logic act,
    output logic first
);

    localparam int unsigned H_TOTAL = timing_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int unsigned V_TOTAL = timing_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
    localparam int unsigned HW      = cnt_width(H_TOTAL);
    localparam int unsigned VW      = cnt_width(V_TOTAL);

    localparam logic [HW-1:0] H_LAST_C  = HW'(H_TOTAL - 32'd1);
    localparam logic [HW-1:0] H_SYNC_C  = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_S_C = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_ACT_E_C = HW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [VW-1:0] V_LAST_C  = VW'(V_TOTAL - 32'd1);
    localparam logic [VW-1:0] V_SYNC_C  = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_S_C = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_ACT_E_C = VW'(V_SYNC + V_BP + V_ACTIVE);

    logic [HW-1:0] h_cnt_r;
    logic [VW-1:0] v_cnt_r;
    logic          act_h_s;
    logic          act_v_s;

    // Position counters: h wraps every line, v advances on each h wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r <= {HW{1'b0}};
            v_cnt_r <= {VW{1'b0}};
        end else if (h_cnt_r == H_LAST_C) begin
            h_cnt_r <= {HW{1'b0}};
            if (v_cnt_r == V_LAST_C) begin
                v_cnt_r <= {VW{1'b0}};
            end else begin
                v_cnt_r <= v_cnt_r + VW'(1);
            end
        end else begin
            h_cnt_r <= h_cnt_r + HW'(1);
        end
    end

    assign act_h_s = (h_cnt_r >= H_ACT_S_C) && (h_cnt_r < H_ACT_E_C);
    assign act_v_s = (v_cnt_r >= V_ACT_S_C) && (v_cnt_r < V_ACT_E_C);

    assign sync_h = (h_cnt_r < H_SYNC_C);
    assign sync_v = (v_cnt_r < V_SYNC_C);
    assign act    = act_h_s && act_v_s;
    assign first  = act_h_s && act_v_s && (h_cnt_r == H_ACT_S_C) && (v_cnt_r == V_ACT_S_C);

endmodule

// File: rtl/video_sync_gen_p.sv
// ----------------------------------------------------------------------------
// video_sync_gen_p
// Parametrised panel timing generator with a valid/ready/sop pixel stream.
// The stream is locked to the frame by waiting for a start-of-packet word at
// the first visible pixel; underflow or a misplaced sop drops the lock and
// the block re-seeks on its own. Timing never stalls on the stream.
// Ports:
//   clk, reset_n            : pixel clock, asynchronous active-low reset
//   in_data/valid/sop/ready : pixel stream from the frame-buffer reader
//   rgb_out                 : pixel out, zero when blank or on error
//   hd, vd                  : syncs at HS_POL / VS_POL active level
//   den                     : data enable, active-high
//   underflow, sop_err      : one-cycle error pulses
// hd/vd/den/rgb_out/underflow/sop_err are registered (one clock behind the
// counters); in_ready is combinational and never depends on in_data.
// ----------------------------------------------------------------------------
module video_sync_gen_p
    import video_timing_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned H_ACTIVE = 480,
    parameter int unsigned H_FP     = 2,
    parameter int unsigned H_SYNC   = 41,
    parameter int unsigned H_BP     = 2,
    parameter int unsigned V_ACTIVE = 272,
    parameter int unsigned V_FP     = 2,
    parameter int unsigned V_SYNC   = 10,
    parameter int unsigned V_BP     = 2,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sop,
    output logic              in_ready,
    output logic [DATA_W-1:0] rgb_out,
    output logic              hd,
    output logic              vd,
    output logic              den,
    output logic              underflow,
    output logic              sop_err
);

    if ((DATA_W < 32'd1) || (H_ACTIVE < 32'd1) || (H_FP < 32'd1) ||
        (H_SYNC < 32'd1) || (H_BP < 32'd1) || (V_ACTIVE < 32'd1) ||
        (V_FP < 32'd1) || (V_SYNC < 32'd1) || (V_BP < 32'd1)) begin : g_param_check
        $error("video_sync_gen_p: DATA_W and all timing parameters must be >= 1");
    end

    logic        sync_h_s;
    logic        sync_v_s;
    logic        act_s;
    logic        first_s;
    lock_state_e state_r;
    lock_state_e state_nxt_s;
    logic        in_ready_s;
    logic        show_s;
    logic        uf_s;
    logic        se_s;

    logic [DATA_W-1:0] rgb_r;
    logic              hd_r;
    logic              vd_r;
    logic              den_r;
    logic              uf_r;
    logic              se_r;

    video_timing_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (reset_n),
        .sync_h (sync_h_s),
        .sync_v (sync_v_s),
        .act    (act_s),
        .first  (first_s)
    );

    // Lock state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= SEEK;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next lock state: lock on a sop at the first pixel, drop on any
    // active-pixel fault (missing data or sop out of place).
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            SEEK: begin
                if (first_s && in_valid && in_sop) begin
                    state_nxt_s = LOCKED;
                end else begin
                    state_nxt_s = SEEK;
                end
            end
            LOCKED: begin
                if (act_s && (!in_valid || (in_sop != first_s))) begin
                    state_nxt_s = SEEK;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: state_nxt_s = SEEK;
        endcase
    end

    // Stream handshake and per-pixel decisions. In SEEK everything but a
    // sop is drained so the sop reaches the head; the sop itself is taken
    // only at the first pixel. In LOCKED a sop showing up mid-frame is left
    // at the head so the next frame can lock onto it.
    always_comb begin
        in_ready_s = 1'b0;
        show_s     = 1'b0;
        uf_s       = 1'b0;
        se_s       = 1'b0;
        case (state_r)
            SEEK: begin
                in_ready_s = !(in_valid && in_sop) || first_s;
                show_s     = first_s && in_valid && in_sop;
            end
            LOCKED: begin
                in_ready_s = act_s && !(in_valid && in_sop && !first_s);
                if (act_s) begin
                    if (!in_valid) begin
                        uf_s = 1'b1;
                    end else if (in_sop != first_s) begin
                        se_s = 1'b1;
                    end else begin
                        show_s = 1'b1;
                    end
                end else begin
                    show_s = 1'b0;
                end
            end
            default: begin
                in_ready_s = 1'b0;
                show_s     = 1'b0;
            end
        endcase
    end

    assign in_ready = in_ready_s;

    // Output registers: everything visible lags the counters by one clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hd_r  <= ~HS_POL;
            vd_r  <= ~VS_POL;
            den_r <= 1'b0;
            rgb_r <= {DATA_W{1'b0}};
            uf_r  <= 1'b0;
            se_r  <= 1'b0;
        end else begin
            hd_r  <= sync_h_s ? HS_POL : ~HS_POL;
            vd_r  <= sync_v_s ? VS_POL : ~VS_POL;
            den_r <= act_s;
            rgb_r <= show_s ? in_data : {DATA_W{1'b0}};
            uf_r  <= uf_s;
            se_r  <= se_s;
        end
    end

    assign rgb_out   = rgb_r;
    assign hd        = hd_r;
    assign vd        = vd_r;
    assign den       = den_r;
    assign underflow = uf_r;
    assign sop_err   = se_r;

endmodule
